// File: rtl/dual_dispatch_ctrl.sv
// Dual-issue dispatch front end: throttles the instruction queue, holds up to four
// in-order instructions and dispatches up to two per cycle under RS credit limits.
// Optional flush port and logic are built when DISPATCH_FLUSH_EN is defined.
module dual_dispatch_ctrl #(
    parameter int RS_DEPTH = 8,
    parameter int CW       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst1,
    input  logic [31:0] inst2,
    output logic        stall1,
    output logic        stall2,
    input  logic [1:0]  rs_release,
`ifdef DISPATCH_FLUSH_EN
    input  logic        flush,
`endif
    output logic        disp_vld1,
    output logic        disp_vld2,
    output logic [31:0] disp_inst1,
    output logic [31:0] disp_inst2
);

    localparam logic [CW:0] CRED_MAX = (CW+1)'(RS_DEPTH);

    // Slot 0 (head, oldest) lives in buf_q[31:0], slot 3 in buf_q[127:96].
    logic [127:0]  buf_q;
    logic [2:0]    occ;
    logic          f_vld1;
    logic          f_vld2;
    logic [CW-1:0] credits;

    logic [1:0]    iss_n;
    logic [1:0]    arr_n;
    logic [2:0]    keep;
    logic [2:0]    nxt_occ;
    logic [2:0]    space;
    logic [127:0]  buf_nxt;
    logic [CW:0]   cred_sum;
    logic [CW-1:0] cred_nxt;
    logic          flush_i;
    logic [5:0]    s0_dest;
    logic          s0_branch;
    logic          raw;

`ifdef DISPATCH_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Returns {valid, register}; stores, branches and writes to r0 produce no destination.
    function automatic logic [5:0] dest_of(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [5:0] d;
        if (op == 6'h00)
            d = {1'b1, rd};
        else if (op == 6'h2B || op == 6'h04 || op == 6'h05)
            d = 6'd0;
        else
            d = {1'b1, rt};
        if (d[4:0] == 5'd0)
            d[5] = 1'b0;
        return d;
    endfunction

    assign s0_dest   = dest_of(buf_q[31:26], buf_q[20:16], buf_q[15:11]);
    assign s0_branch = (buf_q[31:26] == 6'h04) || (buf_q[31:26] == 6'h05);
    assign raw       = s0_dest[5] &&
                       ((s0_dest[4:0] == buf_q[57:53]) || (s0_dest[4:0] == buf_q[52:48]));

    always_comb begin
        iss_n = 2'd0;
        if (occ >= 3'd1 && credits != '0) begin
            iss_n = 2'd1;
            if (occ >= 3'd2 && credits >= CW'(2) && !s0_branch && !raw)
                iss_n = 2'd2;
        end
        if (flush_i)
            iss_n = 2'd0;
    end

    assign arr_n   = {1'b0, f_vld1} + {1'b0, f_vld2};
    assign keep    = occ - {1'b0, iss_n};
    assign nxt_occ = keep + {1'b0, arr_n};
    assign space   = 3'd4 - nxt_occ;

    // Queue handshake: a request is made in any cycle where stall1=0 (plus a second
    // instruction when stall2=0 too); the queue presents the requested instructions
    // on inst1/inst2 in the following cycle with no valid signal of its own. Space is
    // counted after this cycle's issue and arrivals, so every request always fits.
    assign stall1 = ~rst_n | flush_i | (space == 3'd0);
    assign stall2 = stall1 | (space < 3'd2);

    always_comb begin
        buf_nxt = buf_q >> {iss_n, 5'd0};
        for (int j = 0; j < 4; j++) begin
            if (f_vld1 && keep == 3'(j))
                buf_nxt[j*32 +: 32] = inst1;
            if (f_vld2 && (keep + 3'd1) == 3'(j))
                buf_nxt[j*32 +: 32] = inst2;
        end
    end

    // Release and issue net out; the count saturates at the RS depth.
    assign cred_sum = {1'b0, credits} - (CW+1)'(iss_n) + (CW+1)'(rs_release);
    assign cred_nxt = (cred_sum > CRED_MAX) ? CRED_MAX[CW-1:0] : cred_sum[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            occ        <= 3'd0;
            f_vld1     <= 1'b0;
            f_vld2     <= 1'b0;
            credits    <= CW'(RS_DEPTH);
            disp_vld1  <= 1'b0;
            disp_vld2  <= 1'b0;
            disp_inst1 <= '0;
            disp_inst2 <= '0;
        end else begin
            credits   <= cred_nxt;
            f_vld1    <= ~stall1;
            f_vld2    <= ~stall2;
            disp_vld1 <= (iss_n != 2'd0);
            disp_vld2 <= (iss_n == 2'd2);
            if (iss_n != 2'd0)
                disp_inst1 <= buf_q[31:0];
            if (iss_n == 2'd2)
                disp_inst2 <= buf_q[63:32];
            if (flush_i) begin
                occ <= 3'd0;
            end else begin
                occ   <= nxt_occ;
                buf_q <= buf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dual_dispatch_ctrl.sv
// Bench for dual_dispatch_ctrl: a queue model feeds instructions and records the
// expected dispatch order; a negedge monitor pops and compares every dispatch.
module tb_dual_dispatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic        stall1;
  logic        stall2;
  logic [1:0]  rs_release;
`ifdef DISPATCH_FLUSH_EN
  logic        flush;
`endif
  logic        disp_vld1;
  logic        disp_vld2;
  logic [31:0] disp_inst1;
  logic [31:0] disp_inst2;

  int          n_checks = 0;
  int          n_pass = 0;
  int          disp_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];
  logic [9:0]  fill_cnt = '0;

  dual_dispatch_ctrl #(.RS_DEPTH(8), .CW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inst1(inst1),
    .inst2(inst2),
    .stall1(stall1),
    .stall2(stall2),
    .rs_release(rs_release),
`ifdef DISPATCH_FLUSH_EN
    .flush(flush),
`endif
    .disp_vld1(disp_vld1),
    .disp_vld2(disp_vld2),
    .disp_inst1(disp_inst1),
    .disp_inst2(disp_inst2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic pop_check(input string name, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %h expected nothing (no instruction outstanding)", name, got);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  // Directed instructions first, then unique independent fillers (add rd,r0,r0).
  task automatic next_inst(output logic [31:0] ins);
    if (src_q.size() != 0) begin
      ins = src_q.pop_front();
    end else begin
      fill_cnt = fill_cnt + 10'd1;
      ins = {16'h0000, 1'b1, fill_cnt[3:0], fill_cnt[8:4], 6'h20};
    end
  endtask

  // driver: instruction queue model
  initial begin : queue_model
    logic req1;
    logic req2;
    logic fl;
    logic [31:0] ins;
    inst1 = 32'hFFFF_FFFF;
    inst2 = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      req1 = ~stall1;
      req2 = ~stall1 & ~stall2;
`ifdef DISPATCH_FLUSH_EN
      fl = flush;
`else
      fl = 1'b0;
`endif
      if (!rst_n) exp_q.delete();
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      inst1 = 32'hFFFF_FFFF;
      inst2 = 32'hFFFF_FFFF;
      if (req1) begin
        next_inst(ins);
        inst1 = ins;
        exp_q.push_back(ins);
      end
      if (req2) begin
        next_inst(ins);
        inst2 = ins;
        exp_q.push_back(ins);
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (disp_vld2) check("vld2_implies_vld1", 32'(disp_vld1), 32'd1);
      if (disp_vld1) pop_check("disp_inst1", disp_inst1);
      if (disp_vld2) pop_check("disp_inst2", disp_inst2);
      disp_total = disp_total + int'(disp_vld1) + int'(disp_vld2);
    end
  end

  task automatic do_reset(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rel);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    rs_release = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_stall1", 32'(stall1), 32'd1);
    check("reset_stall2", 32'(stall2), 32'd1);
    check("reset_vld1", 32'(disp_vld1), 32'd0);
    check("reset_vld2", 32'(disp_vld2), 32'd0);
    src_q.delete();
    src_q.push_back(a);
    src_q.push_back(b);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rs_release = rel;
  endtask

  task automatic pair_check(input string name, input logic v2, input logic [31:0] i1,
                            input logic [31:0] i2);
    check({name, "_vld1"}, 32'(disp_vld1), 32'd1);
    check({name, "_vld2"}, 32'(disp_vld2), 32'(v2));
    check({name, "_inst1"}, disp_inst1, i1);
    if (v2) check({name, "_inst2"}, disp_inst2, i2);
  endtask

  initial begin : main
    int base;
    rs_release = 2'd0;
`ifdef DISPATCH_FLUSH_EN
    flush = 1'b0;
`endif

    // Independent pair, then credit exhaustion with no releases.
    do_reset(32'h00221820, 32'h00E83020, 2'd0);
    base = disp_total;
    repeat (4) @(negedge clk);
    pair_check("indep", 1'b1, 32'h00221820, 32'h00E83020);
    repeat (30) @(posedge clk);
    #3;
    check("exhaust_count", 32'(disp_total - base), 32'd8);
    check("exhaust_stall1", 32'(stall1), 32'd1);
    check("exhaust_stall2", 32'(stall2), 32'd1);
    check("exhaust_vld1", 32'(disp_vld1), 32'd0);
    rs_release = 2'd2;
    @(posedge clk);
    #3;
    rs_release = 2'd0;
    repeat (10) @(posedge clk);
    #3;
    check("release2_count", 32'(disp_total - base), 32'd10);

    // RAW on r3 through rs: add issues alone, sub follows.
    do_reset(32'h00221820, 32'h00652022, 2'd0);
    repeat (4) @(negedge clk);
    pair_check("raw_rs_c3", 1'b0, 32'h00221820, 32'h0);
    @(negedge clk);
    check("raw_rs_c4_inst1", disp_inst1, 32'h00652022);
    check("raw_rs_c4_vld1", 32'(disp_vld1), 32'd1);
    rs_release = 2'd2;
    repeat (25) @(posedge clk);

    // Branch in slot 0 dispatches alone.
    do_reset(32'h10220003, 32'h00E83020, 2'd0);
    repeat (4) @(negedge clk);
    pair_check("branch_c3", 1'b0, 32'h10220003, 32'h0);
    @(negedge clk);
    check("branch_c4_inst1", disp_inst1, 32'h00E83020);
    rs_release = 2'd1;
    repeat (25) @(posedge clk);

    // Load writes rt=r5, consumer reads r5 through rt.
    do_reset(32'h8C250000, 32'h00E53020, 2'd0);
    repeat (4) @(negedge clk);
    pair_check("raw_rt", 1'b0, 32'h8C250000, 32'h0);

    // Store has no destination: same consumer pairs.
    do_reset(32'hAC250000, 32'h00E53020, 2'd0);
    repeat (4) @(negedge clk);
    pair_check("store_pair", 1'b1, 32'hAC250000, 32'h00E53020);

    // Destination r0 is no destination.
    do_reset(32'h00220020, 32'h00001820, 2'd0);
    repeat (4) @(negedge clk);
    pair_check("r0_pair", 1'b1, 32'h00220020, 32'h00001820);

    // Releases against a full credit count saturate at 8.
    do_reset(32'h00221820, 32'h00E83020, 2'd2);
    base = disp_total;
    @(posedge clk);
    @(posedge clk);
    #3;
    rs_release = 2'd0;
    repeat (30) @(posedge clk);
    #3;
    check("saturate_count", 32'(disp_total - base), 32'd8);

`ifdef DISPATCH_FLUSH_EN
    // Flush with three buffered and one arriving instruction.
    do_reset(32'h00221820, 32'h00652022, 2'd0);
    repeat (3) @(posedge clk);
    #3;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall1", 32'(stall1), 32'd1);
    check("flush_stall2", 32'(stall2), 32'd1);
    @(posedge clk);
    #3;
    flush = 1'b0;
    @(negedge clk);
    check("flush_vld1", 32'(disp_vld1), 32'd0);
    check("flush_vld2", 32'(disp_vld2), 32'd0);
    rs_release = 2'd2;
    repeat (25) @(posedge clk);
`endif

    rs_release = 2'd0;
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_dispatch_ctrl.md
Name: dual_dispatch_ctrl

Overview:
Consumer end of the instruction-queue interface. Throttles the dual-output instruction queue via stall1/stall2, buffers returned instructions in a 4-entry in-order slot buffer, and dispatches up to two per cycle to the reservation station. Dispatch is limited by RS credits and intra-pair hazards. Sits between the instruction queue and the reservation stations.

Parameters:
RS_DEPTH, 8, reservation-station entries; initial and maximum credit count
CW, 4, credit counter width; must hold RS_DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst1  in  32  queue output, older instruction
inst2  in  32  queue output, younger instruction
stall1  out  1  1 = queue must not advance
stall2  out  1  1 = queue must not supply a second instruction
rs_release  in  2  RS entries freed this cycle (0..2)
disp_vld1  out  1  disp_inst1 valid
disp_vld2  out  1  disp_inst2 valid; only set with disp_vld1
disp_inst1  out  32  older dispatched instruction
disp_inst2  out  32  younger dispatched instruction

Behaviour:
- Reset, asynchronous on rst_n low:
  - Clear buffer (occ=0), f_vld1/f_vld2=0, disp_* = 0, credits=RS_DEPTH.
  - stall1=stall2=1 while rst_n=0. This is forced because the queue has no reset.
- Fetch tracking, registered:
  - f_vld1 <= ~stall1.
  - f_vld2 <= ~stall1 & ~stall2.
  - inst1/inst2 are valid in the cycle after the request.
  - arr_n = f_vld1 + f_vld2.
- Decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
  - dest = rd if op==0; none if op in {0x2B store, 0x04, 0x05 branch}; else rt.
  - dest r0 counts as none.
- Issue, combinational from registered state:
  - slot0 issues if occ>=1 and credits>=1.
  - slot1 also issues if:
    - occ>=2 and credits>=2,
    - slot0 is not a branch,
    - no RAW: dest(slot0) is not equal to rs(slot1) or rt(slot1).
  - iss_n is 0, 1 or 2, always in order.
- Flow control, combinational:
  - space = 4 - (occ - iss_n + arr_n).
  - stall1 = (space<1).
  - stall2 = (space<2) | stall1.
  - Never overflows: anything requested now arrives next cycle and is written the cycle after.
- At posedge:
  - Buffer shifts out iss_n from head, then appends valid arrivals in order (inst1 before inst2).
  - disp_vld1 <= (iss_n>=1); disp_vld2 <= (iss_n==2); disp_inst1/2 <= issued slot contents.
  - Unissued disp_inst fields hold their previous value.
  - credits <= min(RS_DEPTH, credits - iss_n + rs_release). Over-release saturates silently.
- Latency: inst arrives in cycle N, is written to a slot at the end of N, and is visible at disp_* in cycle N+2 at best.
- Simultaneous events: release and issue in the same cycle net out. Issue uses pre-update credits.
- Empty buffer with zero arrivals: stall1=stall2=0, disp_vld* = 0.

Optional Feature:
DISPATCH_FLUSH_EN:
- When defined, adds input flush (1 bit).
- flush=1 at posedge:
  - Clears occ, f_vld1/f_vld2 and disp_vld*; in-flight arrivals are dropped.
  - Credits unchanged, except rs_release still applies.
  - Flush overrides issue in that cycle.
  - stall1=stall2=1 during the flush cycle.
- When undefined, the port is absent and there is no flush logic.

Test Plan:
- Reset, then stream 0x00221820 (add r3,r1,r2), 0x00E83020 (add r6,r7,r8) -> stall1=stall2=1 in reset; after release, both appear with disp_vld1=disp_vld2=1 in a single cycle.
- Pair 0x00221820 then 0x00652022 (sub r4,r3,r5) -> RAW on r3: first cycle disp_vld1=1, disp_vld2=0; sub dispatches alone next cycle.
- rs_release=0, continuous independent stream -> exactly 8 instructions dispatched, then disp_vld*=0. Buffer fills to 4 and stall1=stall2=1. One release pulse of 2 -> 2 more dispatched.
- Branch 0x10220003 in slot0 with independent slot1 -> branch dispatches alone; the next cycle dispatches slot1.
- credits=8 with rs_release=2 and no issue -> credits stay at 8 (saturation).
- Under DISPATCH_FLUSH_EN: flush with occ=3 and f_vld1=1 -> next cycle occ=0 and disp_vld*=0; no flushed instruction ever dispatches.
